// File: rtl/branch_recovery_ctrl_if.sv
// rtl/branch_recovery_ctrl_if.sv - fetch/execute side signal bundle for branch_recovery_ctrl
interface branch_recovery_ctrl_if #(
  parameter int PC_W = 32
);
  logic            pred_valid;
  logic            pred_taken;
  logic [PC_W-1:0] target_pc;
  logic [PC_W-1:0] fallthru_pc;
  logic            pred_ready;
  logic            ex_valid;
  logic            ex_outcome;
  logic            upd_valid;
  logic            upd_outcome;
  logic            flush;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            err_underflow;

  modport master (
    output pred_valid, pred_taken, target_pc, fallthru_pc, ex_valid, ex_outcome,
    input  pred_ready, upd_valid, upd_outcome, flush, redirect_valid, redirect_pc,
    input  err_underflow
  );

  modport slave (
    input  pred_valid, pred_taken, target_pc, fallthru_pc, ex_valid, ex_outcome,
    output pred_ready, upd_valid, upd_outcome, flush, redirect_valid, redirect_pc,
    output err_underflow
  );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// rtl/branch_recovery_ctrl.sv - in-flight branch queue with mispredict flush/redirect (optional BP_STATS_EN counters)
module branch_recovery_ctrl #(
  parameter int PC_W         = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  branch_recovery_ctrl_if.slave   bus
`ifdef BP_STATS_EN
  ,
  output logic [15:0]             stat_branches,
  output logic [15:0]             stat_mispredicts
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [FC_W-1:0]  FLUSH_LD  = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state;
  logic [FC_W-1:0]  flush_cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic             q_taken  [DEPTH];
  logic [PC_W-1:0]  q_target [DEPTH];
  logic [PC_W-1:0]  q_fall   [DEPTH];

  logic             upd_valid_r, upd_outcome_r, flush_r, redirect_valid_r, err_r;
  logic [PC_W-1:0]  redirect_pc_r;

  logic push, pop, mispredict, underflow_evt, ready;

  // Accept pushes only in IDLE with a free slot; a pop this cycle does not free one early.
  always_comb begin
    ready         = (state == IDLE) && (count != FULL_CNT);
    push          = bus.pred_valid && ready;
    pop           = bus.ex_valid && (state == IDLE) && (count != '0);
    mispredict    = pop && (q_taken[rd_ptr] != bus.ex_outcome);
    underflow_evt = bus.ex_valid && (state == IDLE) && (count == '0);
  end

  // Queue payload: written on push, never reset (contents qualified by count).
  always_ff @(posedge clk) begin
    if (push) begin
      q_taken[wr_ptr]  <= bus.pred_taken;
      q_target[wr_ptr] <= bus.target_pc;
      q_fall[wr_ptr]   <= bus.fallthru_pc;
    end
  end

  // Control FSM, queue pointers and registered strobes toward fetch and predictor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      flush_cnt        <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      upd_valid_r      <= 1'b0;
      upd_outcome_r    <= 1'b0;
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
      err_r            <= 1'b0;
    end else begin
      upd_valid_r      <= pop;
      upd_outcome_r    <= pop && bus.ex_outcome;
      redirect_valid_r <= mispredict;
      if (underflow_evt) err_r <= 1'b1;
      case (state)
        IDLE: begin
          if (mispredict) begin
            // Everything younger than the resolving branch is wrong-path, including this cycle's push.
            redirect_pc_r <= bus.ex_outcome ? q_target[rd_ptr] : q_fall[rd_ptr];
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            state         <= FLUSH;
            flush_r       <= 1'b1;
            flush_cnt     <= FLUSH_LD;
          end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state   <= IDLE;
            flush_r <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BP_STATS_EN
  // Saturating resolve and mispredict counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop && stat_branches != 16'hFFFF)           stat_branches    <= stat_branches + 1'b1;
      if (mispredict && stat_mispredicts != 16'hFFFF) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`endif

  assign bus.pred_ready     = ready;
  assign bus.upd_valid      = upd_valid_r;
  assign bus.upd_outcome    = upd_outcome_r;
  assign bus.flush          = flush_r;
  assign bus.redirect_valid = redirect_valid_r;
  assign bus.redirect_pc    = redirect_pc_r;
  assign bus.err_underflow  = err_r;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// tb/tb_branch_recovery_ctrl.sv - directed self-checking bench for branch_recovery_ctrl
module tb_branch_recovery_ctrl;
  localparam int PC_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  branch_recovery_ctrl_if #(.PC_W(PC_W)) bus ();
`ifdef BP_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts;
`endif

  branch_recovery_ctrl #(.PC_W(PC_W), .DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs set afterwards hold across the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic tk, input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] fall);
    bus.pred_valid = 1'b1; bus.pred_taken = tk; bus.target_pc = tgt; bus.fallthru_pc = fall;
    tick();
    bus.pred_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pred_valid = 0; bus.pred_taken = 0; bus.target_pc = 0; bus.fallthru_pc = 0;
    bus.ex_valid = 0; bus.ex_outcome = 0;
    tick(); tick();
    check("rst_flush", bus.flush, 0);
    check("rst_redir_v", bus.redirect_valid, 0);
    check("rst_redir_pc", bus.redirect_pc, 0);
    check("rst_upd_v", bus.upd_valid, 0);
    check("rst_err", bus.err_underflow, 0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", bus.pred_ready, 1);

    // Three correct predictions
    push(0, 32'h10, 32'h14); push(1, 32'h20, 32'h24); push(0, 32'h30, 32'h34);
    bus.ex_valid = 1; bus.ex_outcome = 0; tick();
    check("ok1_upd_v", bus.upd_valid, 1); check("ok1_upd_o", bus.upd_outcome, 0);
    check("ok1_flush", bus.flush, 0);
    bus.ex_outcome = 1; tick();
    check("ok2_upd_v", bus.upd_valid, 1); check("ok2_upd_o", bus.upd_outcome, 1);
    check("ok2_redir", bus.redirect_valid, 0);
    bus.ex_outcome = 0; tick();
    check("ok3_upd_v", bus.upd_valid, 1); check("ok3_upd_o", bus.upd_outcome, 0);
    check("ok3_flush", bus.flush, 0);
    bus.ex_valid = 0; tick();
    check("ok_idle_upd", bus.upd_valid, 0); check("ok_ready", bus.pred_ready, 1);

    // Mispredict predicted not-taken, actually taken
    push(0, 32'h100, 32'h44);
    bus.ex_valid = 1; bus.ex_outcome = 1; tick();
    bus.ex_valid = 0;
    check("mp_redir_v", bus.redirect_valid, 1); check("mp_redir_pc", bus.redirect_pc, 32'h100);
    check("mp_flush1", bus.flush, 1); check("mp_upd_o", bus.upd_outcome, 1);
    check("mp_ready0", bus.pred_ready, 0);
    tick();
    check("mp_flush2", bus.flush, 1); check("mp_redir_1shot", bus.redirect_valid, 0);
    tick();
    check("mp_flush_end", bus.flush, 0); check("mp_ready1", bus.pred_ready, 1);

    // Mispredict predicted taken, actually not taken -> fallthrough
    push(1, 32'h200, 32'h48);
    bus.ex_valid = 1; bus.ex_outcome = 0; tick();
    bus.ex_valid = 0;
    check("mp2_redir_pc", bus.redirect_pc, 32'h48); check("mp2_flush", bus.flush, 1);
    tick(); tick();
    check("mp2_flush_end", bus.flush, 0);

    // Fill to full, drop a fifth push, then drain
    push(0, 32'h1, 32'h2); push(0, 32'h3, 32'h4); push(0, 32'h5, 32'h6); push(0, 32'h7, 32'h8);
    check("full_ready0", bus.pred_ready, 0);
    push(1, 32'hBAD, 32'hBAD);
    check("full_drop_ready", bus.pred_ready, 0);
    bus.ex_valid = 1; bus.ex_outcome = 0; tick();
    check("full_pop_ready", bus.pred_ready, 1); check("full_pop_upd", bus.upd_valid, 1);
    tick(); tick(); tick();
    check("drain_flush", bus.flush, 0); check("drain_upd", bus.upd_valid, 1);
    check("pre_err", bus.err_underflow, 0);
    tick();
    check("uf_err", bus.err_underflow, 1); check("uf_upd", bus.upd_valid, 0);
    bus.ex_valid = 0; tick();
    check("uf_sticky", bus.err_underflow, 1); check("uf_upd2", bus.upd_valid, 0);

    // Simultaneous push and pop keeps order
    push(0, 32'h9, 32'hA);
    bus.pred_valid = 1; bus.pred_taken = 1; bus.target_pc = 32'h300; bus.fallthru_pc = 32'h304;
    bus.ex_valid = 1; bus.ex_outcome = 0; tick();
    bus.pred_valid = 0;
    check("pp_upd", bus.upd_valid, 1); check("pp_flush", bus.flush, 0);
    bus.ex_outcome = 1; tick();
    bus.ex_valid = 0;
    check("pp2_upd_o", bus.upd_outcome, 1); check("pp2_redir", bus.redirect_valid, 0);

    // Mispredict with same-cycle push; ex_valid during flush ignored
    push(0, 32'h400, 32'h404);
    bus.pred_valid = 1; bus.pred_taken = 0; bus.target_pc = 32'h500; bus.fallthru_pc = 32'h504;
    bus.ex_valid = 1; bus.ex_outcome = 1; tick();
    bus.pred_valid = 0; bus.ex_outcome = 0;
    check("wp_redir_pc", bus.redirect_pc, 32'h400); check("wp_flush", bus.flush, 1);
    tick();
    bus.ex_valid = 0;
    check("wp_ex_ignored", bus.upd_valid, 0); check("wp_flush2", bus.flush, 1);
    tick();
    check("wp_flush_end", bus.flush, 0);
    push(1, 32'h600, 32'h604);
    bus.ex_valid = 1; bus.ex_outcome = 0; tick();
    bus.ex_valid = 0;
    check("wp_empty_redir", bus.redirect_valid, 1); check("wp_empty_pc", bus.redirect_pc, 32'h604);
    tick(); tick();

    // Reset on first flush cycle
    rst_n = 0; tick(); rst_n = 1; tick();
`ifdef BP_STATS_EN
    push(1, 32'h700, 32'h704);
    bus.ex_valid = 1; bus.ex_outcome = 0; tick();
    bus.ex_valid = 0;
    check("st_br", stat_branches, 1); check("st_mp", stat_mispredicts, 1);
`else
    push(1, 32'h700, 32'h704);
    bus.ex_valid = 1; bus.ex_outcome = 0; tick();
    bus.ex_valid = 0;
`endif
    check("rf_flush_on", bus.flush, 1);
    rst_n = 0; tick();
    check("rf_flush", bus.flush, 0); check("rf_redir", bus.redirect_valid, 0);
    check("rf_err", bus.err_underflow, 0); check("rf_ready", bus.pred_ready, 1);
`ifdef BP_STATS_EN
    check("rf_st_br", stat_branches, 0); check("rf_st_mp", stat_mispredicts, 0);
`endif
    rst_n = 1; tick();
    check("rf_idle_flush", bus.flush, 0); check("rf_idle_ready", bus.pred_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_recovery_ctrl.md
BRANCH_RECOVERY_CTRL -- requirements
Module: branch_recovery_ctrl

Interface
REQ-001 Parameters SHALL be: PC_W, default 32, PC width; DEPTH, default 4, in-flight branch queue entries (power of 2, >=2); FLUSH_CYCLES, default 2, flush pulse length (>=1).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 pred_valid  input  1  fetch issued a predicted branch this cycle.
REQ-005 pred_taken  input  1  predictor output for that branch.
REQ-006 target_pc, fallthru_pc  input  PC_W each  taken target / sequential PC of that branch.
REQ-007 pred_ready  output  1  queue can accept a push (combinational: not full and state IDLE).
REQ-008 ex_valid  input  1  branch resolved in EX this cycle.
REQ-009 ex_outcome  input  1  resolved direction, 1 = taken.
REQ-010 upd_valid, upd_outcome  output  1 each  registered training strobe/direction to the predictor.
REQ-011 flush  output  1  squash IF/ID; redirect_valid  output  1; redirect_pc  output  PC_W.
REQ-012 err_underflow  output  1  sticky: ex_valid arrived with empty queue.

Function
REQ-013 Queue SHALL be a DEPTH-entry FIFO of {pred_taken, target_pc, fallthru_pc}; push on pred_valid & pred_ready; pop on ex_valid in IDLE with queue non-empty.
REQ-014 pred_valid while pred_ready=0 SHALL be dropped; no queue change.
REQ-015 Simultaneous push and pop SHALL both occur; count unchanged; full queue with pop SHALL accept the push the same cycle only if pred_ready (i.e. not full) -- pop does not free a slot combinationally.
REQ-016 Pointers SHALL wrap modulo DEPTH; count SHALL be 0..DEPTH.
REQ-017 For a pop at edge N: cycle N+1 upd_valid=1, upd_outcome=ex_outcome, for exactly one cycle.
REQ-018 Mispredict = head.pred_taken != ex_outcome; on mispredict at edge N: redirect_valid=1 for one cycle at N+1, redirect_pc = ex_outcome ? head.target_pc : head.fallthru_pc.
REQ-019 On mispredict the whole queue SHALL be cleared at edge N, including any push presented that cycle (wrong path).
REQ-020 FSM states: IDLE, FLUSH. IDLE->FLUSH on mispredict; flush=1 for exactly FLUSH_CYCLES cycles starting N+1 via down-counter; FLUSH->IDLE when counter reaches zero.
REQ-021 In FLUSH: pred_ready=0, ex_valid ignored (no pop, no upd_valid, no error).
REQ-022 Correct prediction SHALL produce no flush/redirect; state stays IDLE.
REQ-023 ex_valid with empty queue in IDLE SHALL set err_underflow, no pop, no upd_valid; cleared only by reset.

Reset
REQ-024 rst_n=0 at a clock edge SHALL empty queue, state IDLE, counter 0, and drive flush, redirect_valid, upd_valid, upd_outcome, err_underflow to 0 and redirect_pc to 0, overriding any operation in progress including a mid-FLUSH sequence.
REQ-025 Queue payload storage need not be reset; pred_ready SHALL be 1 the first cycle after reset release.

Configuration
REQ-026 Macro BP_STATS_EN: when defined, outputs stat_branches[15:0] and stat_mispredicts[15:0] SHALL exist, incrementing on each pop / each mispredict, saturating at 16'hFFFF, reset to 0.
REQ-027 Without BP_STATS_EN these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-028 Reset then push 3 branches (taken=0,1,0), resolve with outcomes 0,1,0 -> three upd_valid pulses, upd_outcome 0,1,0, flush never asserted.
REQ-029 Push taken=0, target 0x100, fallthru 0x44; resolve outcome 1 -> next cycle redirect_valid=1, redirect_pc=0x100, flush high exactly 2 cycles, queue empty, pred_ready back to 1 after.
REQ-030 Push 4 branches with no resolves -> pred_ready=0; 5th pred_valid dropped; pop one -> pred_ready=1 next cycle.
REQ-031 ex_valid with empty queue -> err_underflow=1 persists; upd_valid stays 0.
REQ-032 Mispredict with simultaneous push and ex_valid during following FLUSH -> push dropped, ex_valid ignored, count 0.
REQ-033 Assert rst_n=0 on first flush cycle -> next cycle flush=0, state IDLE, with BP_STATS_EN stat counters 0.
